// File: rtl/s820_bist.sv
// Self-test wrapper for the s820 core. An LFSR drives the core inputs, a MISR
// compacts the core outputs, and a small FSM sequences the clear/run/done phases.
module s820_bist #(
  parameter int          PAT_W         = 16,
  parameter logic [17:0] SEED_ZERO_SUB = 18'h00001
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [17:0]      seed,
  input  logic [PAT_W-1:0] num_patterns,
  input  logic [18:0]      dut_resp,
  output logic [17:0]      dut_stim,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic [18:0]      signature
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PAT_W-1:0] CNT_ONE = PAT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [17:0]      lfsr;
  logic [18:0]      misr;
  logic [PAT_W-1:0] count;
  logic [PAT_W-1:0] np_lat;
  logic             armed;
  logic             launch;
  logic             last_vec;

  // Fibonacci LFSR, x^18 + x^11 + 1.
  function automatic logic [17:0] lfsr_step(input logic [17:0] l);
    return {l[16:0], l[17] ^ l[10]};
  endfunction

  // MISR, x^19 + x^6 + x^2 + x + 1; the top bit feeds back into taps 0, 1, 2, 6.
  function automatic logic [18:0] misr_step(input logic [18:0] m, input logic [18:0] r);
    logic [18:0] n;
    n[0] = r[0] ^ m[18];
    for (int i = 1; i < 19; i++) begin
      n[i] = m[i-1] ^ r[i];
    end
    n[1] = n[1] ^ m[18];
    n[2] = n[2] ^ m[18];
    n[6] = n[6] ^ m[18];
    return n;
  endfunction

  // A start that coincides with reset release is dropped; armed goes high one edge later.
  assign launch   = start && armed && ((state == IDLE) || (state == DONE));
  assign last_vec = (count == (np_lat - CNT_ONE));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = CLEAR;
      CLEAR:   state_nxt = (np_lat != '0) ? RUN : DONE;
      RUN:     if (last_vec) state_nxt = DONE;
      DONE:    if (launch) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == CLEAR) || (state == RUN);
    done      = (state == DONE);
    dut_reset = (state != RUN);
    dut_stim  = (state == RUN) ? lfsr : 18'h0;
    signature = misr;
  end

  // Datapath: loaded on launch, advanced only in RUN, held everywhere else.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      lfsr   <= '0;
      misr   <= '0;
      count  <= '0;
      np_lat <= '0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (launch) begin
        np_lat <= num_patterns;
        lfsr   <= (seed == 18'h0) ? SEED_ZERO_SUB : seed;
        misr   <= '0;
        count  <= '0;
      end else if (state == RUN) begin
        misr  <= misr_step(misr, dut_resp);
        lfsr  <= lfsr_step(lfsr);
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_s820_bist.sv
// Directed-plus-random bench for s820_bist against an arithmetic model of the
// LFSR stimulus stream and polynomial MISR compaction.
module tb_s820_bist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [17:0] seed;
  logic [15:0] num_patterns;
  logic [18:0] dut_resp;
  logic [17:0] dut_stim;
  logic        dut_reset;
  logic        busy;
  logic        done;
  logic [18:0] signature;

  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] resp_tab [0:63];
  logic [18:0] resp_const;
  logic [18:0] sig_a, sig_b, sig_c;
  logic [17:0] s_rand;

  s820_bist dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .start          (start),
    .seed           (seed),
    .num_patterns   (num_patterns),
    .dut_resp       (dut_resp),
    .dut_stim       (dut_stim),
    .dut_reset      (dut_reset),
    .busy           (busy),
    .done           (done),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: LFSR as multiply-by-two modulo 2^18 plus feedback parity.
  function automatic logic [17:0] ref_lfsr(input logic [17:0] l);
    int v;
    v = int'(l);
    return 18'((v * 2) % 262144 + (((v >> 17) ^ (v >> 10)) & 1));
  endfunction

  // Reference: MISR as polynomial shift; overflow out of x^18 is reduced by 0x47.
  function automatic logic [18:0] ref_misr(input logic [18:0] m, input logic [18:0] r);
    int v;
    int fb;
    v  = int'(m);
    fb = (v >> 18) & 1;
    v  = ((v * 2) % 524288) ^ int'(r) ^ (fb * 'h47);
    return 19'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: constant response, 1: table response, 2: random response.
  // flip: cycle whose response gets one bit inverted; pulse: cycle where start is re-pulsed.
  task automatic run(input logic [17:0] s, input int np, input int mode,
                     input int flip, input int pulse, output logic [18:0] sig);
    logic [17:0] l;
    logic [18:0] m;
    logic [18:0] r;
    seed         = s;
    num_patterns = 16'(np);
    start        = 1'b1;
    step();
    start = 1'b0;
    check("clr_busy", busy, 1);
    check("clr_reset", dut_reset, 1);
    check("clr_stim", dut_stim, 0);
    check("clr_sig", signature, 0);
    l = (s == 18'h0) ? 18'h00001 : s;
    m = '0;
    for (int k = 0; k < np; k++) begin
      step();
      check("run_stim", dut_stim, l);
      check("run_reset", dut_reset, 0);
      check("run_busy", busy, 1);
      r = (mode == 0) ? resp_const : (mode == 1) ? resp_tab[k % 64] : 19'($urandom);
      if (k == flip) r = r ^ 19'h00010;
      dut_resp = r;
      if (k == pulse) begin
        start        = 1'b1;
        seed         = ~s;
        num_patterns = 16'(np + 5);
      end else begin
        start = 1'b0;
      end
      m = ref_misr(m, r);
      l = ref_lfsr(l);
    end
    step();
    start = 1'b0;
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_stim", dut_stim, 0);
    check("done_reset", dut_reset, 1);
    check("done_sig", signature, m);
    step();
    step();
    check("done_hold", done, 1);
    check("sig_hold", signature, m);
    sig = signature;
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    seed         = '0;
    num_patterns = '0;
    dut_resp     = '0;
    resp_const   = '0;
    for (int i = 0; i < 64; i++) resp_tab[i] = 19'($urandom);

    // Reset held across toggling clock edges.
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stim", dut_stim, 0);
    check("rst_dreset", dut_reset, 1);
    check("rst_sig", signature, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Zero seed substitution, zero responses.
    resp_const = 19'h00000;
    run(18'h0, 3, 0, -1, -1, sig_a);
    check("zero_seed_sig", sig_a, 19'h00000);

    // Top-bit seed, constant response of 1.
    resp_const = 19'h00001;
    run(18'h20000, 2, 0, -1, -1, sig_a);
    check("seed_msb_sig", sig_a, 19'h00003);

    // Empty run goes CLEAR -> DONE directly.
    run(18'h12345, 0, 2, -1, -1, sig_a);
    check("empty_sig", sig_a, 19'h00000);

    // Random seeds, counts and responses.
    for (int t = 0; t < 5; t++) begin
      run(18'($urandom), int'($urandom_range(1, 24)), 2, -1, -1, sig_a);
    end

    // Start re-pulsed mid-run must not alter the run.
    run(18'($urandom), 8, 2, -1, 3, sig_a);
    run(18'($urandom), 5, 2, -1, 4, sig_a);

    // Reset asserted in the middle of a run.
    seed         = 18'h0abcd;
    num_patterns = 16'd10;
    start        = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("mid_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_stim", dut_stim, 0);
    check("abort_dreset", dut_reset, 1);
    check("abort_sig", signature, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    check("abort_idle", busy, 0);
    run(18'($urandom), 12, 2, -1, -1, sig_a);

    // Start coinciding with reset release is ignored, honoured one edge later.
    rst_n        = 1'b0;
    dut_resp     = 19'h5a5a5;
    seed         = 18'h00005;
    num_patterns = 16'd1;
    start        = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rel_ignored", busy, 0);
    step();
    check("rel_honoured", busy, 1);
    start = 1'b0;
    begin
      int wait_cnt;
      wait_cnt = 0;
      while (!done && wait_cnt < 10) begin
        step();
        wait_cnt++;
      end
    end
    check("rel_done", done, 1);
    check("rel_sig", signature, ref_misr(19'h0, 19'h5a5a5));

    // Repeatability and single-bit sensitivity of the signature.
    s_rand = 18'($urandom);
    run(s_rand, 16, 1, -1, -1, sig_a);
    run(s_rand, 16, 1, -1, -1, sig_b);
    run(s_rand, 16, 1, 5, -1, sig_c);
    check("repeat_same", sig_a, sig_b);
    check("flip_differs", 32'(sig_a != sig_c), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
